// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, BITS clocks per product.
// Optional two's-complement mode is enabled by defining SHIFT_ADD_MULTIPLIER_SIGNED_EN (adds port i_signed).
module shift_add_multiplier #(
  parameter int BITS = 8
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [BITS-1:0]     i_multiplicand,
  input  logic [BITS-1:0]     i_multiplier,
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
  input  logic                i_signed,
`endif
  output logic                o_busy,
  output logic                o_finished,
  output logic [2*BITS-1:0]   o_product,
  output logic [1:0]          o_state
);

  localparam int CW = $clog2(BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2*BITS-1:0] a_q;
  logic [BITS-1:0]   b_q;
  logic [2*BITS-1:0] acc_q;
  logic [2*BITS-1:0] acc_next;
  logic [2*BITS-1:0] addend;
  logic [CW-1:0]     count_q;
  logic              accept;
  logic              last_bit;
  logic              a_ext;

`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
  logic              signed_q;
  assign a_ext = i_signed & i_multiplicand[BITS-1];
`else
  assign a_ext = 1'b0;
`endif

  // i_start is only honoured outside RUN; reset wins over start.
  assign accept   = i_start && (state != RUN);
  assign last_bit = (count_q == LAST_BIT);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    if (i_start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // In signed mode the multiplier's MSB has weight -2^(BITS-1), so the last
  // partial product is subtracted instead of added.
  always_comb begin
    addend   = b_q[0] ? a_q : '0;
    acc_next = acc_q + addend;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    if (signed_q && last_bit) begin
      acc_next = acc_q - addend;
    end
`endif
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else if (accept) begin
      a_q     <= {{BITS{a_ext}}, i_multiplicand};
      b_q     <= i_multiplier;
      acc_q   <= '0;
      count_q <= '0;
    end else if (state == RUN) begin
      a_q     <= a_q << 1;
      b_q     <= b_q >> 1;
      acc_q   <= acc_next;
      count_q <= count_q + 1'b1;
    end
  end

`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      signed_q <= 1'b0;
    end else if (accept) begin
      signed_q <= i_signed;
    end
  end
`endif

  // Partial sums stay internal; the product is only visible in DONE.
  assign o_busy     = (state == RUN);
  assign o_finished = (state == DONE);
  assign o_product  = (state == DONE) ? acc_q : '0;
  assign o_state    = state;

endmodule
